// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state enum
// and counter-width helper.
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = a - b - bi, with borrow-out.
module full_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = a_i ^ b_i ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~a_i & bi_i) | (b_i & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             cell_d;
    logic             cell_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_subtractor_cell u_cell (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .bi_i (brw_q),
        .d_o  (cell_d),
        .bo_o (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                d_d   = (d_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                brw_d = cell_bo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    // brw_q here is the borrow into the MSB
                    ovf_d   = brw_q ^ cell_bo;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); checks Ovf
// when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t bp_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   bp_rand = 1'b0;
    bit   bp_val = 1'b1;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : bp_val;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic bin);
        exp_t e;
        int unsigned ua;
        int unsigned ub;
        int sa;
        int sb;
        int r;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        e.bout = (ua < ub + bin);
        e.d = W'(ua - ub - bin);
        r = sa - sb - int'(bin);
        e.ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("D", D, mon_e.d);
                chk("Bout", Bout, mon_e.bout);
`ifdef SERIAL_SUB_OVF_EN
                chk("Ovf", Ovf, mon_e.ovf);
`endif
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input bit push);
        int t = 0;
        A = a;
        B = b;
        Bin = bin;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        else if (push) q.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_D"}, D, 0);
        chk({nm, "_Bout"}, Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_Ovf"}, Ovf, 0);
`endif
    endtask

    initial begin
        int lat;
        int t;
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(8'h35, 8'h12, 1'b0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        chk("latency", lat, W + 1);
        drain();

        do_op(8'h00, 8'h01, 1'b0, 1'b1);
        do_op(8'h10, 8'h0F, 1'b1, 1'b1);
        do_op(8'h80, 8'h01, 1'b0, 1'b1);
        do_op(8'h05, 8'h03, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 1'b1, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        drain();

        bp_val = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_op(8'h5A, 8'h3C, 1'b1, 1'b1);
        bp_e = model(8'h5A, 8'h3C, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_reach_done", out_valid, 1);
        in_valid = 1'b1;
        A = 8'hFF;
        B = 8'h00;
        Bin = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("bp_D", D, bp_e.d);
            chk("bp_Bout", Bout, bp_e.bout);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        bp_val = 1'b1;
        drain();
        chk("bp_back_idle", in_ready, 1);

        do_op(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale_valid", seen, 0);
        do_op(8'h09, 8'h04, 1'b0, 1'b1);
        drain();

        bp_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        drain();
        bp_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
